// File: rtl/json_frame_receiver.sv
// json_frame_receiver: UART byte receiver feeding a brace-depth framer that
// captures one complete JSON object ('{' .. matching '}') into a buffer and
// holds it until the consumer acknowledges it.
// Optional feature: define JSON_RX_TIMEOUT_EN to abort a frame that stalls
// in COLLECT for TIMEOUT_BITS bit-times with no new byte.
module json_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned MAX_BYTES    = 32,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             uart_in,
    output logic                             frame_valid,
    output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len,
    input  logic                             frame_ack,
    input  logic [$clog2(MAX_BYTES)-1:0]     rd_addr,
    output logic [BITS_N-1:0]                rd_data,
    output logic                             err_framing,
    output logic                             err_overflow,
    output logic                             err_timeout
);

    localparam int unsigned LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int unsigned ADDR_W = $clog2(MAX_BYTES);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;
    localparam logic [BITS_N-1:0] LBRACE = BITS_N'(8'h7B);
    localparam logic [BITS_N-1:0] RBRACE = BITS_N'(8'h7D);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {F_HUNT, F_COLLECT, F_HOLD} fr_state_t;

    // ---------------- synchronizer ----------------
    logic       r_sync1, r_sync2, r_prev;
    logic [1:0] r_flush;

    // Two-flop synchronizer; r_prev only tracks real line samples once the
    // reset value has flushed out, so a start needs the line seen high first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_flush <= 2'b00;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= uart_in;
            r_sync2 <= r_sync1;
            r_flush <= {r_flush[0], 1'b1};
            r_prev  <= r_flush[1] & r_sync2;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t          r_rx_state, w_rx_state_n;
    logic [CNT_W-1:0]   r_clk_cnt, w_clk_cnt_n;
    logic [BIT_W-1:0]   r_bit_idx, w_bit_idx_n;
    logic [BITS_N-1:0]  r_shift, w_shift_n;
    logic               r_rx_valid, w_rx_valid_n;
    logic               r_rx_ferr, w_rx_ferr_n;

    // Receiver state register; byte strobes land one cycle after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_clk_cnt  <= w_clk_cnt_n;
            r_bit_idx  <= w_bit_idx_n;
            r_shift    <= w_shift_n;
            r_rx_valid <= w_rx_valid_n;
            r_rx_ferr  <= w_rx_ferr_n;
        end
    end

    // Receiver next-state: mid-bit sampling, LSB first, stop bit checked.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_clk_cnt_n  = r_clk_cnt + CNT_W'(1);
        w_bit_idx_n  = r_bit_idx;
        w_shift_n    = r_shift;
        w_rx_valid_n = 1'b0;
        w_rx_ferr_n  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_clk_cnt_n = '0;
                if (r_prev && !r_sync2) begin
                    w_rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (r_clk_cnt == CNT_W'(HALF - 1)) begin
                    w_clk_cnt_n = '0;
                    w_bit_idx_n = '0;
                    w_rx_state_n = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_clk_cnt_n = '0;
                    w_shift_n   = {r_sync2, r_shift[BITS_N-1:1]};
                    if (r_bit_idx == BIT_W'(BITS_N - 1)) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_clk_cnt_n  = '0;
                    w_rx_state_n = RX_IDLE;
                    w_rx_valid_n = r_sync2;
                    w_rx_ferr_n  = ~r_sync2;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- frame FSM ----------------
    fr_state_t          r_state, w_state_n;
    logic [3:0]         r_depth, w_depth_n;
    logic [LEN_W-1:0]   r_count, w_count_n;
    logic [LEN_W-1:0]   r_frame_len, w_frame_len_n;
    logic               r_frame_valid, w_frame_valid_n;
    logic               r_err_framing, w_err_framing_n;
    logic               r_err_overflow, w_err_overflow_n;
    logic               r_err_timeout, w_err_timeout_n;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [BITS_N-1:0]  r_mem [MAX_BYTES];
    logic [BITS_N-1:0]  r_rd_data;

`ifdef JSON_RX_TIMEOUT_EN
    localparam int unsigned TOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TOUT_W    = $clog2(TOUT_CLKS + 1);
    logic [TOUT_W-1:0] r_tout_cnt, w_tout_cnt_n;

    // Inter-byte timeout counter, only meaningful while collecting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tout_cnt <= '0;
        end else begin
            r_tout_cnt <= w_tout_cnt_n;
        end
    end
`endif

    // Frame state register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= F_HUNT;
            r_depth        <= '0;
            r_count        <= '0;
            r_frame_len    <= '0;
            r_frame_valid  <= 1'b0;
            r_err_framing  <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_depth        <= w_depth_n;
            r_count        <= w_count_n;
            r_frame_len    <= w_frame_len_n;
            r_frame_valid  <= w_frame_valid_n;
            r_err_framing  <= w_err_framing_n;
            r_err_overflow <= w_err_overflow_n;
            r_err_timeout  <= w_err_timeout_n;
        end
    end

    // Frame next-state: hunt for '{', track brace depth, hold until ack.
    always_comb begin
        w_state_n        = r_state;
        w_depth_n        = r_depth;
        w_count_n        = r_count;
        w_frame_len_n    = r_frame_len;
        w_frame_valid_n  = r_frame_valid;
        w_err_framing_n  = 1'b0;
        w_err_overflow_n = 1'b0;
        w_err_timeout_n  = 1'b0;
        w_we             = 1'b0;
        w_waddr          = '0;
`ifdef JSON_RX_TIMEOUT_EN
        w_tout_cnt_n     = '0;
`endif
        if (r_rx_ferr) begin
            w_err_framing_n = 1'b1;
            if (r_state == F_COLLECT) begin
                w_state_n = F_HUNT;
                w_depth_n = '0;
            end
        end else begin
            case (r_state)
                F_HUNT: begin
                    if (r_rx_valid && r_shift == LBRACE) begin
                        w_we      = 1'b1;
                        w_waddr   = '0;
                        w_count_n = LEN_W'(1);
                        w_depth_n = 4'd1;
                        w_state_n = F_COLLECT;
                    end
                end
                F_COLLECT: begin
                    if (r_rx_valid) begin
                        if ((r_shift == LBRACE && r_depth == 4'hF) ||
                            r_count == LEN_W'(MAX_BYTES)) begin
                            w_err_overflow_n = 1'b1;
                            w_state_n        = F_HUNT;
                            w_depth_n        = '0;
                        end else begin
                            w_we      = 1'b1;
                            w_waddr   = ADDR_W'(r_count);
                            w_count_n = r_count + LEN_W'(1);
                            if (r_shift == LBRACE) begin
                                w_depth_n = r_depth + 4'd1;
                            end else if (r_shift == RBRACE) begin
                                w_depth_n = r_depth - 4'd1;
                                if (r_depth == 4'd1) begin
                                    w_frame_len_n   = r_count + LEN_W'(1);
                                    w_frame_valid_n = 1'b1;
                                    w_state_n       = F_HOLD;
                                end
                            end
                        end
                    end
`ifdef JSON_RX_TIMEOUT_EN
                    else if (r_tout_cnt == TOUT_W'(TOUT_CLKS - 1)) begin
                        w_err_timeout_n = 1'b1;
                        w_state_n       = F_HUNT;
                        w_depth_n       = '0;
                    end else begin
                        w_tout_cnt_n = r_tout_cnt + TOUT_W'(1);
                    end
`endif
                end
                F_HOLD: begin
                    if (frame_ack) begin
                        w_frame_valid_n = 1'b0;
                        w_state_n       = F_HUNT;
                        w_depth_n       = '0;
                    end
                end
                default: begin
                    w_state_n = F_HUNT;
                    w_depth_n = '0;
                end
            endcase
        end
    end

    // Frame buffer write port.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= r_shift;
        end
    end

    // Registered buffer read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign frame_valid  = r_frame_valid;
    assign frame_len    = r_frame_len;
    assign rd_data      = r_rd_data;
    assign err_framing  = r_err_framing;
    assign err_overflow = r_err_overflow;
    assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_json_frame_receiver.sv
// Directed bench for json_frame_receiver: serial JSON frames, nesting,
// overflow at the buffer limit, hold/ack behaviour, framing error, timeout
// and reset mid-byte.
module tb_json_frame_receiver;

    localparam int unsigned C      = 16;
    localparam int unsigned MAXB   = 13;
    localparam int unsigned LEN_W  = $clog2(MAXB + 1);
    localparam int unsigned ADDR_W = $clog2(MAXB);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              uart_in;
    logic              frame_valid;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              err_framing, err_overflow, err_timeout;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0, n_ovf = 0, n_tout = 0;

    json_frame_receiver #(
        .CLKS_PER_BIT(C), .BITS_N(8), .MAX_BYTES(MAXB), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_in(uart_in),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .err_framing(err_framing), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Count single-cycle error pulses.
    always @(posedge clk) begin
        if (rst_n) begin
            if (err_framing)  n_ferr <= n_ferr + 1;
            if (err_overflow) n_ovf  <= n_ovf + 1;
            if (err_timeout)  n_tout <= n_tout + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk); uart_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (C) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (C) @(negedge clk);
        uart_in = 1'b1;
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic chk_rd(input int a, input logic [7:0] e, input string tag);
        @(negedge clk); rd_addr = ADDR_W'(a);
        @(negedge clk);
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic chk_frame(input string s, input string tag);
        chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
        chk({tag, "_len"}, 32'(frame_len), 32'(s.len()));
        for (int i = 0; i < s.len(); i++) chk_rd(i, s[i], {tag, "_byte"});
    endtask

    task automatic ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", 32'(frame_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; uart_in = 1'b1; frame_ack = 1'b0; rd_addr = '0;
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_len", 32'(frame_len), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_errs", {29'd0, err_framing, err_overflow, err_timeout}, 32'd0);
        rst_n = 1'b1;
        repeat (4 * C) @(negedge clk);

        // Leading garbage dropped; frame starts at '{'.
        send_str("ab{\"T\":1}");
        chk_frame("{\"T\":1}", "simple");
        chk_rd(2, 8'h54, "simple_T");
        ack();

        // Nested object: inner '}' must not close; closes at exactly MAX bytes.
        send_str("{\"a\":{\"b\":2}");
        chk("nested_not_done", 32'(frame_valid), 32'd0);
        send_str("}");
        chk_frame("{\"a\":{\"b\":2}}", "nested");
        chk("nested_no_ovf", 32'(n_ovf), 32'd0);
        ack();

        // Fourteenth byte overflows the 13-byte buffer.
        send_str("{123456789ABCD}");
        chk("ovf_pulse", 32'(n_ovf), 32'd1);
        chk("ovf_no_valid", 32'(frame_valid), 32'd0);
        send_str("{}");
        chk_frame("{}", "after_ovf");

        // Bytes during HOLD are dropped; ack in HOLD releases.
        send_str("{x}");
        chk_frame("{}", "hold_stable");
        ack();
        send_str("{y}");
        chk_frame("{y}", "next_frame");
        ack();

        // Ack outside HOLD is ignored.
        ack();

        // Framing error aborts COLLECT back to HUNT.
        send_str("{");
        send_byte(8'h41, 1'b0);
        chk("ferr_pulse", 32'(n_ferr), 32'd1);
        send_str("}");
        chk("ferr_hunt", 32'(frame_valid), 32'd0);

        // Idle in COLLECT longer than 20 bit-times.
        send_str("{");
        repeat (25 * C) @(negedge clk);
        send_str("}");
`ifdef JSON_RX_TIMEOUT_EN
        chk("tout_pulse", 32'(n_tout), 32'd1);
        chk("tout_hunt", 32'(frame_valid), 32'd0);
`else
        chk("tout_none", 32'(n_tout), 32'd0);
        chk_frame("{}", "tout_collect");
        ack();
`endif

        // Reset mid-byte while a frame is held.
        send_str("{}");
        chk("pre_rst_valid", 32'(frame_valid), 32'd1);
        @(negedge clk); uart_in = 1'b0;
        repeat (3 * C) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        chk("midrst_len", 32'(frame_len), 32'd0);
        chk("midrst_rd", 32'(rd_data), 32'd0);
        chk("midrst_errs", {29'd0, err_framing, err_overflow, err_timeout}, 32'd0);
        uart_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * C) @(negedge clk);
        send_str("{}");
        chk_frame("{}", "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
